// File: rtl/store_result_monitor.sv
// store_result_monitor: judges the core's pass/fail store protocol and logs every judged store.
//   clk, reset                     : clock and synchronous active-high reset
//   MemWrite, DataAdr, WriteData   : store bus from the core
//   log_ready / log_valid          : host drain handshake for the first-word-fall-through store log
//   log_addr, log_data             : head entry of the log
//   log_overflow                   : sticky, a store was dropped on a full log
//   store_count                    : judged stores since reset, saturating
//   done, pass, fail, timeout      : one-hot verdicts and their OR
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_VALUE     = 32'd25,
  parameter logic [31:0] ALLOW_ADDR     = 32'd96,
  parameter int          LOG_DEPTH      = 8,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        log_ready,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic [15:0] store_count,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);
  localparam int AW = $clog2(LOG_DEPTH);
  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;
  state_t state, state_nx;
  logic [31:0] cyc;
  logic [AW:0] wp, rp, occ;
  logic [63:0] mem [LOG_DEPTH];
  logic store, hit_pass, terminate, expire, pop, push_ok;
  assign store     = MemWrite && state == S_RUN;
  assign hit_pass  = DataAdr == PASS_ADDR;
  assign terminate = store && (hit_pass || DataAdr != ALLOW_ADDR);
  assign expire    = TIMEOUT_CYCLES != 0 && state == S_RUN && !terminate && cyc == 32'(TIMEOUT_CYCLES - 1);
  // Pointers carry one extra bit so a full log is distinguishable from an empty one.
  assign occ       = wp - rp;
  assign log_valid = occ != '0;
  assign pop       = log_valid && log_ready;
  assign push_ok   = !occ[AW] || pop;
  assign {log_addr, log_data} = mem[rp[AW-1:0]];
  assign pass      = state == S_PASS;
  assign fail      = state == S_FAIL;
  assign timeout   = state == S_TIMEOUT;
  assign done      = pass || fail || timeout;
  always_comb begin
    state_nx = !terminate ? (expire ? S_TIMEOUT : state)
             : (hit_pass && WriteData == PASS_VALUE) ? S_PASS : S_FAIL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RUN;
      cyc          <= '0;
      store_count  <= '0;
      log_overflow <= 1'b0;
      wp           <= '0;
      rp           <= '0;
    end else begin
      state <= state_nx;
      if (state == S_RUN && !terminate) cyc <= cyc + 32'd1;
      if (store && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
      if (pop) rp <= rp + 1'b1;
      if (store && push_ok) wp <= wp + 1'b1;
      if (store && !push_ok) log_overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && store && push_ok) mem[wp[AW-1:0]] <= {DataAdr, WriteData};
  end
endmodule

// File: tb/tb_store_result_monitor.sv
// tb_store_result_monitor: randomized and directed checks of store_result_monitor against a queue-based model.
module tb_store_result_monitor;
  logic        clk = 1'b0;
  logic        reset, MemWrite, log_ready;
  logic [31:0] DataAdr, WriteData;
  logic        log_valid, log_overflow, done, pass, fail, timeout;
  logic [31:0] log_addr, log_data;
  logic [15:0] store_count;
  int tests_run = 0;
  int fails = 0;
  // Model: verdict (0 run, 1 pass, 2 fail, 3 timeout), RUN cycles seen, count, overflow, log contents.
  int          m_st, m_cyc, m_cnt;
  bit          m_ovf;
  logic [63:0] q[$];

  store_result_monitor #(.LOG_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .log_ready(log_ready), .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow), .store_count(store_count), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit popped;
    reset = r; MemWrite = w; DataAdr = a; WriteData = d; log_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_st = 0; m_cyc = 0; m_cnt = 0; m_ovf = 0; q.delete();
    end else begin
      popped = q.size() != 0 && rdy;
      if (popped) void'(q.pop_front());
      if (m_st == 0 && w) begin
        if (m_cnt < 65535) m_cnt++;
        if (q.size() < 8) q.push_back({a, d}); else m_ovf = 1;
        if (a == 100) m_st = (d == 25) ? 1 : 2;
        else if (a != 96) m_st = 2;
      end
      if (m_st == 0) begin
        if (m_cyc == 15) m_st = 3; else m_cyc++;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tests_run++;
    if ({done, pass, fail, timeout, log_valid, log_overflow, store_count} !== 22'd0) begin
      fails++; $display("FAIL reset_outputs got %b %h want all zero", {done, pass, fail, timeout, log_valid, log_overflow}, store_count);
    end
  endtask

  task automatic test_pass_sequence;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'd96, 32'd7, 1'b0);
    tests_run++;
    if ({done, pass} !== 2'b00) begin fails++; $display("FAIL allow_stays_run got done/pass=%b want 00", {done, pass}); end
    tick(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
    tests_run++;
    if ({done, pass, fail, timeout} !== 4'b1100) begin fails++; $display("FAIL pass_verdict got %b want 1100", {done, pass, fail, timeout}); end
    tests_run++;
    if (store_count !== 16'd2) begin fails++; $display("FAIL pass_count got %0d want 2", store_count); end
    tests_run++;
    if ({log_valid, log_addr, log_data} !== {1'b1, 32'd96, 32'd7}) begin fails++; $display("FAIL log_head0 got %b %0d %0d want 1 96 7", log_valid, log_addr, log_data); end
    idle(1'b1);
    tests_run++;
    if ({log_valid, log_addr, log_data} !== {1'b1, 32'd100, 32'd25}) begin fails++; $display("FAIL log_head1 got %b %0d %0d want 1 100 25", log_valid, log_addr, log_data); end
    idle(1'b1);
    tests_run++;
    if (log_valid !== 1'b0) begin fails++; $display("FAIL log_drained got %b want 0", log_valid); end
  endtask

  task automatic test_bad_data;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'd100, 32'd24, 1'b0);
    tests_run++;
    if ({fail, pass, store_count} !== {2'b10, 16'd1}) begin fails++; $display("FAIL bad_data got fail=%b pass=%b cnt=%0d want 1 0 1", fail, pass, store_count); end
    tick(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
    tests_run++;
    if ({fail, pass, store_count} !== {2'b10, 16'd1}) begin fails++; $display("FAIL terminal_ignores got fail=%b pass=%b cnt=%0d want 1 0 1", fail, pass, store_count); end
  endtask

  task automatic test_bad_addr;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'd200, 32'd25, 1'b0);
    tests_run++;
    if ({fail, log_valid, log_addr, log_data} !== {2'b11, 32'd200, 32'd25}) begin
      fails++; $display("FAIL bad_addr got fail=%b valid=%b head=%0d,%0d want 1 1 200,25", fail, log_valid, log_addr, log_data);
    end
  endtask

  task automatic test_timeout;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++) idle(1'b0);
    tests_run++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_early got %b want 0 after 15 cycles", timeout); end
    idle(1'b0);
    tests_run++;
    if ({done, timeout} !== 2'b11) begin fails++; $display("FAIL timeout_fire got done/timeout=%b want 11 after 16 cycles", {done, timeout}); end
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++) idle(1'b0);
    tick(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
    tests_run++;
    if ({pass, timeout} !== 2'b10) begin fails++; $display("FAIL store_beats_timeout got pass/timeout=%b want 10", {pass, timeout}); end
  endtask

  task automatic test_overflow;
    int pops;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 32'd96, 32'(i), 1'b0);
    tests_run++;
    if ({log_overflow, store_count} !== {1'b1, 16'd9}) begin fails++; $display("FAIL overflow got ovf=%b cnt=%0d want 1 9", log_overflow, store_count); end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({log_valid, log_data} !== {1'b1, 32'(i)}) begin fails++; $display("FAIL drain_%0d got valid=%b data=%0d want 1 %0d", i, log_valid, log_data, i); end
      idle(1'b1);
    end
    tests_run++;
    if (log_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got %b want 0", log_valid); end
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 32'd96, 32'(i), 1'b0);
    tick(1'b0, 1'b1, 32'd96, 32'd8, 1'b1);
    tests_run++;
    if (log_overflow !== 1'b0) begin fails++; $display("FAIL full_push_pop_ovf got %b want 0", log_overflow); end
    pops = 0;
    while (log_valid === 1'b1 && pops < 20) begin pops++; idle(1'b1); end
    tests_run++;
    if (pops != 8) begin fails++; $display("FAIL full_push_pop_occ got %0d want 8", pops); end
  endtask

  task automatic test_reset_after_pass;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
    tick(1'b1, 1'b1, 32'd96, 32'd5, 1'b0);
    tests_run++;
    if ({done, pass, fail, timeout, log_valid, log_overflow, store_count} !== 22'd0) begin
      fails++; $display("FAIL reset_with_store got %b cnt=%0d want all zero", {done, pass, fail, timeout, log_valid, log_overflow}, store_count);
    end
    tick(1'b0, 1'b1, 32'd100, 32'd25, 1'b0);
    tests_run++;
    if ({pass, store_count, log_addr, log_data} !== {1'b1, 16'd1, 32'd100, 32'd25}) begin
      fails++; $display("FAIL pass_after_reset got pass=%b cnt=%0d head=%0d,%0d want 1 1 100,25", pass, store_count, log_addr, log_data);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    int sel;
    tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      a = sel < 70 ? 32'd96 : sel < 85 ? 32'd100 : $urandom;
      d = $urandom_range(0, 1) ? 32'd25 : $urandom_range(0, 40);
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0, a, d, $urandom_range(0, 3) == 0);
      tests_run++;
      if ({done, pass, fail, timeout} !== {m_st != 0, m_st == 1, m_st == 2, m_st == 3}) begin
        fails++; $display("FAIL rand_verdict cyc %0d got %b want state %0d", n, {done, pass, fail, timeout}, m_st);
      end
      tests_run++;
      if ({store_count, log_overflow, log_valid} !== {16'(m_cnt), m_ovf, q.size() != 0}) begin
        fails++; $display("FAIL rand_status cyc %0d got cnt=%0d ovf=%b valid=%b want %0d %b %b", n, store_count, log_overflow, log_valid, m_cnt, m_ovf, q.size() != 0);
      end
      if (q.size() != 0) begin
        tests_run++;
        if ({log_addr, log_data} !== q[0]) begin
          fails++; $display("FAIL rand_head cyc %0d got %h want %h", n, {log_addr, log_data}, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_pass_sequence;
    test_bad_data;
    test_bad_addr;
    test_timeout;
    test_overflow;
    test_reset_after_pass;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/store_result_monitor.md
Name: store_result_monitor

Overview:
Synthesizable on-chip responder for the core's data-store interface (MemWrite/DataAdr/WriteData) exported from the processor top. It judges the program's pass/fail store protocol in hardware: a store of PASS_VALUE to PASS_ADDR means pass, stores to ALLOW_ADDR are scratch traffic, and any other store means fail. It also logs every judged store into a small FIFO that a host drains over a valid/ready handshake. It sits beside the data memory on the store bus, so FPGA runs report results without a simulator.

Parameters:
PASS_ADDR, 100, store address that signals completion
PASS_VALUE, 25, data required at PASS_ADDR for pass
ALLOW_ADDR, 96, scratch address whose stores are tolerated
LOG_DEPTH, 8, store-log FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 1000, RUN cycles before timeout; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
MemWrite  in  1  store strobe from core
DataAdr  in  32  store address
WriteData  in  32  store data
log_ready  in  1  host accepts log head this cycle
log_valid  out  1  log FIFO non-empty
log_addr  out  32  address of log head entry
log_data  out  32  data of log head entry
log_overflow  out  1  sticky; a store was dropped because log was full
store_count  out  16  judged stores since reset, saturating at 0xFFFF
done  out  1  pass | fail | timeout
pass  out  1  pass verdict
fail  out  1  bad-store verdict
timeout  out  1  timeout verdict

Behaviour:
- Reset (sampled at rising clk with reset=1): state=RUN, all outputs 0, cycle counter 0, FIFO empty. Takes priority over everything, including a same-cycle store or pop. Reset mid-run or after a verdict fully restarts the block.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal until reset. pass/fail/timeout are registered, one-hot, and equal to (state==PASS/FAIL/TIMEOUT). done is their OR.
- In RUN, a store is MemWrite=1 at a rising edge. The store is judged as follows, in priority order:
  - DataAdr==PASS_ADDR and WriteData==PASS_VALUE -> PASS.
  - DataAdr==PASS_ADDR with any other data -> FAIL.
  - DataAdr==ALLOW_ADDR -> stay in RUN.
  - Any other address -> FAIL.
- The verdict is visible the cycle after the store edge (1-cycle latency).
- Every store in RUN, including the terminating one, is judged. Each judged store increments store_count, which saturates at 0xFFFF, and is pushed to the log. In terminal states MemWrite is ignored: no count, no log.
- Timeout: the cycle counter increments on each RUN edge that has no terminating store. When it equals TIMEOUT_CYCLES-1 on such an edge, next state is TIMEOUT. timeout therefore rises after exactly TIMEOUT_CYCLES RUN cycles. A terminating store on that same edge wins. When TIMEOUT_CYCLES=0 the counter never fires.
- Log FIFO:
  - First-word-fall-through: log_addr/log_data show the head whenever log_valid=1. Their value is don't-care when empty.
  - Pop happens when log_valid & log_ready.
  - A push when full, with no same-cycle pop, drops the new entry and sets log_overflow. log_overflow stays set until reset.
  - Push and pop on the same edge while full: both occur, nothing is dropped, occupancy is unchanged.
  - Push and pop on the same edge while empty: push only; the entry appears the next cycle.
  - Popping continues after a verdict, so the host can drain the log at any time.
- Comparisons are full 32-bit equality. No byte enables; a store is a whole-word event.

Test Plan:
1. Reset, then stores (96,7), (100,25) on consecutive edges -> pass=1, done=1 one cycle after second store; fail=timeout=0; store_count=2; with log_ready=1 the log yields (96,7) then (100,25), then log_valid=0.
2. Store (100,24) -> fail=1 next cycle; store_count=1. A later (100,25) leaves pass=0 and store_count=1.
3. Store (200,25) -> fail=1; the log head is (200,25).
4. TIMEOUT_CYCLES=16, no stores -> timeout=1 exactly 16 cycles after reset deasserts. Repeat with store (100,25) on the 16th RUN edge -> pass=1, timeout=0.
5. LOG_DEPTH=8, log_ready=0, nine stores to (96,i) for i=0..8 -> log_overflow=1 and store_count=9. Draining yields data 0..7 in order. Separately, with the log full, push and pop on the same edge -> no overflow, occupancy stays 8.
6. After PASS, assert reset for one cycle with MemWrite=1 -> next cycle all outputs 0, state RUN, the store is not logged; a following store (100,25) produces pass again.
